// File: rtl/checker_hm_fetch_if.sv
// rtl/checker_hm_fetch_if.sv - MPU fetch port and Wishbone read bus bundle for the host-memory fetch engine
interface checker_hm_fetch_if;
    logic [63:0] hm_addr;
    logic        hm_start;
    logic [63:0] hm_data;
    logic        hm_en;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        input  hm_addr, hm_start, wb_dat_i, wb_ack_i, wb_err_i,
        output hm_data, hm_en, wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o
    );

    modport slave (
        output hm_addr, hm_start, wb_dat_i, wb_ack_i, wb_err_i,
        input  hm_data, hm_en, wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o
    );
endinterface

// File: rtl/checker_hm_fetch.sv
// rtl/checker_hm_fetch.sv - two-beat Wishbone host-memory fetch engine with sticky fault reporting
module checker_hm_fetch #(
    parameter logic [15:0] TIMEOUT   = 16'd1024,
    parameter bit          LOW_FIRST = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               abort,
    checker_hm_fetch_if.master bus,
    output logic               fault,
    output logic [1:0]         fault_code
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FAULT} state_t;

    localparam logic [31:0] FIRST_OFS = LOW_FIRST ? 32'd0 : 32'd4;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic        cyc_q, cyc_d;
    logic        hm_en_q, hm_en_d;
    logic [63:0] data_q, data_d;
    logic [63:0] buf_q, buf_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cyc_q   <= 1'b0;
            hm_en_q <= 1'b1;
            data_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cyc_q   <= cyc_d;
            hm_en_q <= hm_en_d;
            data_q  <= data_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cyc_d   = cyc_q;
        hm_en_d = hm_en_q;
        data_d  = data_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        code_d  = code_q;

        case (state_q)
            IDLE: begin
                if (bus.hm_start) begin
                    if (|bus.hm_addr[63:32]) begin
                        state_d = FAULT;
                        hm_en_d = 1'b0;
                        fault_d = 1'b1;
                        code_d  = 2'b11;
                    end else begin
                        state_d = BEAT0;
                        hm_en_d = 1'b0;
                        cyc_d   = 1'b1;
                        adr_d   = {bus.hm_addr[31:3], 3'b000} | FIRST_OFS;
                        cnt_d   = '0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (bus.wb_err_i) begin
                    state_d = FAULT;
                    cyc_d   = 1'b0;
                    fault_d = 1'b1;
                    code_d  = 2'b01;
                end else if (bus.wb_ack_i) begin
                    // Bit 2 of an 8-byte-aligned beat address selects the half, whatever the issue order.
                    if (adr_q[2])
                        buf_d[63:32] = bus.wb_dat_i;
                    else
                        buf_d[31:0]  = bus.wb_dat_i;
                    cnt_d = '0;
                    if (state_q == BEAT0) begin
                        state_d = BEAT1;
                        adr_d   = adr_q ^ 32'd4;
                    end else begin
                        state_d = IDLE;
                        cyc_d   = 1'b0;
                        hm_en_d = 1'b1;
                        data_d  = buf_d;
                    end
                end else if ((TIMEOUT != 16'd0) && (cnt_q + 16'd1 == TIMEOUT)) begin
                    state_d = FAULT;
                    cyc_d   = 1'b0;
                    fault_d = 1'b1;
                    code_d  = 2'b10;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a start or ack presented in the same cycle.
        if (abort) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
            hm_en_d = 1'b1;
            data_d  = '0;
            cnt_d   = '0;
            fault_d = 1'b0;
            code_d  = 2'b00;
        end
    end

    assign bus.hm_data  = data_q;
    assign bus.hm_en    = hm_en_q;
    assign bus.wb_adr_o = adr_q;
    assign bus.wb_cyc_o = cyc_q;
    assign bus.wb_stb_o = cyc_q;
    assign bus.wb_we_o  = 1'b0;
    assign bus.wb_sel_o = 4'hf;
    assign fault        = fault_q;
    assign fault_code   = code_q;

endmodule
